// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide over WIDTH
// iterations, with a sign fix-up cycle that loads HI/LO. Honours the pipeline freeze halt_i.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             halt_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              sign1_q, sign1_d, sign2_q, sign2_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]  orig_q, orig_d, mag_q, mag_d, rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              last_iter;
    logic              s1, s2;
    logic [WIDTH-1:0]  m1, m2;
    logic [WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!halt_i) begin
            case (state_q)
                StIdle:  if (start_i) state_d = StCalc;
                StCalc:  if (last_iter) state_d = StFix;
                StFix:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Operand magnitudes; signed ops take the two's-complement absolute value.
    always_comb begin
        s1 = op_i[1] & data1_i[WIDTH-1];
        s2 = op_i[1] & data2_i[WIDTH-1];
        m1 = s1 ? (~data1_i + WIDTH'(1)) : data1_i;
        m2 = s2 ? (~data2_i + WIDTH'(1)) : data2_i;
    end

    always_comb begin
        mul_sum   = {1'b0, rem_q} + {1'b0, (quo_q[0] ? mag_q : {WIDTH{1'b0}})};
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        prod      = {rem_q, quo_q};
        prod_neg  = ~prod + (2*WIDTH)'(1);
    end

    // Datapath and registered outputs
    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        dbz_d   = dbz_q;
        orig_d  = orig_q;
        mag_d   = mag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (!halt_i) begin
            busy_d = (state_d != StIdle);
            done_d = (state_q == StFix);
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_d    = op_i;
                        sign1_d = s1;
                        sign2_d = s2;
                        dbz_d   = op_i[0] && (data2_i == '0);
                        orig_d  = data1_i;
                        cnt_d   = '0;
                        rem_d   = '0;
                        // Multiply: quo holds the multiplier; divide: quo holds the dividend.
                        mag_d   = op_i[0] ? m2 : m1;
                        quo_d   = op_i[0] ? m1 : m2;
                    end
                end
                StCalc: begin
                    cnt_d = cnt_q + CntW'(1);
                    if (!op_q[0]) begin
                        rem_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end else if (!div_diff[WIDTH]) begin
                        rem_d = div_diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
                StFix: begin
                    if (!op_q[0]) begin
                        {hi_d, lo_d} = (sign1_q ^ sign2_q) ? prod_neg : prod;
                    end else if (dbz_q) begin
                        hi_d = orig_q;
                        lo_d = '1;
                    end else begin
                        lo_d = (sign1_q ^ sign2_q) ? (~quo_q + WIDTH'(1)) : quo_q;
                        hi_d = sign1_q ? (~rem_q + WIDTH'(1)) : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            op_q    <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            dbz_q   <= 1'b0;
            orig_q  <= '0;
            mag_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            dbz_q   <= dbz_d;
            orig_q  <= orig_d;
            mag_q   <= mag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, halt/reset/back-to-back timing and
// randomized operations against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        halt_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] data1_i = '0;
    logic [31:0] data2_i = '0;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .halt_i  (halt_i),
        .start_i (start_i),
        .op_i    (op_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p = {32'h0, a} * {32'h0, b};
                {hi, lo} = p;
            end
            2'b10: begin
                p = sa * sb;
                {hi, lo} = p;
            end
            default: begin
                if (b == 0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'b01) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
        endcase
    endfunction

    // Start an op, run until done_o (bounded). restart_at >= 0 re-asserts start_i after that edge.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int restart_at, output int lat, output logic [31:0] hi,
                          output logic [31:0] lo, output bit busy_ok);
        op_i = op;
        data1_i = a;
        data2_i = b;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        lat = 0;
        busy_ok = busy_o;
        while (lat < 100) begin
            if (lat == restart_at) begin
                start_i = 1'b1;
                op_i = ~op;
                data1_i = $urandom;
                data2_i = $urandom;
            end
            step();
            lat++;
            start_i = 1'b0;
            if (done_o) break;
            if (!busy_o) busy_ok = 1'b0;
        end
        hi = hi_o;
        lo = lo_o;
        if (busy_o) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done got %b want 0", done_o); else n_pass++;
        n_checks++; if (hi_o !== 32'h0) $display("FAIL reset_hi got %h want 0", hi_o); else n_pass++;
        n_checks++; if (lo_o !== 32'h0) $display("FAIL reset_lo got %h want 0", lo_o); else n_pass++;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [8] = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3};
        logic [31:0] as  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'd100, 32'd100, 32'hFFFF_FFF9};
        logic [31:0] bs  [8] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                                 32'hFFFF_FFFF, 32'd0, 32'd7, 32'd0};
        logic [31:0] ehi [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF,
                                 32'h0, 32'd100, 32'd2, 32'hFFFF_FFF9};
        logic [31:0] elo [8] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFD,
                                 32'h8000_0000, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF};
        int lat;
        logic [31:0] hi, lo;
        bit busy_ok;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], -1, lat, hi, lo, busy_ok);
            n_checks++; if (hi !== ehi[i]) $display("FAIL dir%0d_hi got %h want %h", i, hi, ehi[i]); else n_pass++;
            n_checks++; if (lo !== elo[i]) $display("FAIL dir%0d_lo got %h want %h", i, lo, elo[i]); else n_pass++;
            n_checks++; if (lat != 33) $display("FAIL dir%0d_latency got %0d want 33", i, lat); else n_pass++;
            n_checks++; if (!busy_ok) $display("FAIL dir%0d_busy got glitch want high E0..E32", i); else n_pass++;
            step();
            n_checks++; if (done_o !== 1'b0) $display("FAIL dir%0d_done_pulse got %b want 0", i, done_o); else n_pass++;
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        logic [31:0] hi, lo;
        bit busy_ok;
        // restart_at=4: second start is sampled at E5.
        run_op(2'd1, 32'd100, 32'd7, 4, lat, hi, lo, busy_ok);
        n_checks++; if (lo !== 32'd14) $display("FAIL ign_start_lo got %h want %h", lo, 32'd14); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL ign_start_hi got %h want %h", hi, 32'd2); else n_pass++;
        n_checks++; if (lat != 33) $display("FAIL ign_start_latency got %0d want 33", lat); else n_pass++;
        step();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL ign_start_idle got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_halt();
        int lat;
        // start_i is ignored while halted.
        halt_i = 1'b1;
        start_i = 1'b1;
        op_i = 2'd0;
        data1_i = 32'd12345;
        data2_i = 32'd678;
        step();
        step();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL halt_start_busy got %b want 0", busy_o); else n_pass++;
        halt_i = 1'b0;
        step();
        start_i = 1'b0;
        lat = 0;
        repeat (10) begin step(); lat++; end
        halt_i = 1'b1;
        repeat (5) begin step(); lat++; end
        n_checks++; if (busy_o !== 1'b1) $display("FAIL halt_busy_hold got %b want 1", busy_o); else n_pass++;
        halt_i = 1'b0;
        while (!done_o && lat < 100) begin step(); lat++; end
        n_checks++; if (lat != 38) $display("FAIL halt_latency got %0d want 38", lat); else n_pass++;
        n_checks++; if (lo_o !== 32'd8369910) $display("FAIL halt_lo got %h want %h", lo_o, 32'd8369910); else n_pass++;
        n_checks++; if (hi_o !== 32'd0) $display("FAIL halt_hi got %h want 0", hi_o); else n_pass++;
        halt_i = 1'b1;
        step();
        n_checks++; if (done_o !== 1'b1) $display("FAIL halt_done_hold1 got %b want 1", done_o); else n_pass++;
        step();
        n_checks++; if (done_o !== 1'b1) $display("FAIL halt_done_hold2 got %b want 1", done_o); else n_pass++;
        halt_i = 1'b0;
        step();
        n_checks++; if (done_o !== 1'b0) $display("FAIL halt_done_clear got %b want 0", done_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int lat;
        logic [31:0] hi, lo;
        bit busy_ok;
        op_i = 2'd3;
        data1_i = 32'hFFFF_FFF9;
        data2_i = 32'd2;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (19) step();
        rst_i = 1'b1;
        halt_i = 1'b1;
        step();
        rst_i = 1'b0;
        halt_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy_o); else n_pass++;
        n_checks++; if (done_o !== 1'b0) $display("FAIL rstmid_done got %b want 0", done_o); else n_pass++;
        n_checks++; if (hi_o !== 32'h0) $display("FAIL rstmid_hi got %h want 0", hi_o); else n_pass++;
        n_checks++; if (lo_o !== 32'h0) $display("FAIL rstmid_lo got %h want 0", lo_o); else n_pass++;
        seen = 1'b0;
        repeat (40) begin step(); if (done_o) seen = 1'b1; end
        n_checks++; if (seen) $display("FAIL rstmid_no_done got done want none"); else n_pass++;
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, -1, lat, hi, lo, busy_ok);
        n_checks++; if (lat != 33) $display("FAIL rstmid_fresh_latency got %0d want 33", lat); else n_pass++;
        n_checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL rstmid_fresh_lo got %h want fffffffd", lo); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL rstmid_fresh_hi got %h want ffffffff", hi); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        op_i = 2'd0;
        data1_i = 32'd3;
        data2_i = 32'd5;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (32) step();
        start_i = 1'b1;
        op_i = 2'd1;
        data1_i = 32'd100;
        data2_i = 32'd7;
        step();
        n_checks++; if (done_o !== 1'b1) $display("FAIL b2b_e33_done got %b want 1", done_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL b2b_e33_busy got %b want 0", busy_o); else n_pass++;
        n_checks++; if (lo_o !== 32'd15) $display("FAIL b2b_first_lo got %h want %h", lo_o, 32'd15); else n_pass++;
        step();
        start_i = 1'b0;
        n_checks++; if (done_o !== 1'b0) $display("FAIL b2b_e34_done got %b want 0", done_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b1) $display("FAIL b2b_e34_busy got %b want 1", busy_o); else n_pass++;
        lat = 0;
        while (!done_o && lat < 100) begin step(); lat++; end
        n_checks++; if (lat != 33) $display("FAIL b2b_second_latency got %0d want 33", lat); else n_pass++;
        n_checks++; if (lo_o !== 32'd14 || hi_o !== 32'd2)
            $display("FAIL b2b_second_result got %h:%h want 2:e", hi_o, lo_o); else n_pass++;
        step();
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, ehi, elo, hi, lo;
        int lat;
        bit busy_ok;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: begin a = a & 32'hFF; b = (b & 32'hF) | 32'h1; end
                4: b = b & 32'hFFFF;
                default: ;
            endcase
            model(op, a, b, ehi, elo);
            run_op(op, a, b, -1, lat, hi, lo, busy_ok);
            n_checks++;
            if (hi !== ehi || lo !== elo || lat != 33)
                $display("FAIL rand%0d op%0d %h,%h got %h:%h lat %0d want %h:%h lat 33",
                         i, op, a, b, hi, lo, lat, ehi, elo);
            else n_pass++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the two operand values and an operation code latched by ID/EX and runs a radix-2 shift-add multiply or a restoring divide over 32 iterations. It writes a 64-bit result into HI/LO registers and asserts `busy_o` so hazard logic can stall the front end. It honours the same `halt_i` freeze that holds the pipeline registers during data-cache misses.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Iteration count equals `WIDTH`; the counter is `$clog2(WIDTH)+1` bits.

Ports:
- `clk_i`  in  1: single clock; all state updates on the rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `halt_i`  in  1: pipeline freeze; all internal state and outputs hold.
- `start_i`  in  1: request from EX decode; sampled only in IDLE.
- `op_i`  in  2: 00 MULTU, 01 DIVU, 10 MULT (signed), 11 DIV (signed).
- `data1_i`  in  WIDTH: multiplicand or dividend (rs value from ID/EX).
- `data2_i`  in  WIDTH: multiplier or divisor (rt value from ID/EX).
- `hi_o`  out  WIDTH: product upper half, or remainder.
- `lo_o`  out  WIDTH: product lower half, or quotient.
- `busy_o`  out  1: high while an operation is in progress.
- `done_o`  out  1: one-cycle completion pulse, extended while halted.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE → CALC: on an edge with `start_i`=1 and `halt_i`=0.
  - Latch `op_i` and the operand signs.
  - Latch operand magnitudes. For signed ops, take the two's-complement absolute value; |0x80000000| = 2^31 as unsigned.
  - Latch a divide-by-zero flag when the op is a divide and `data2_i`=0.
  - Clear the iteration count.
- CALC: each unhalted edge performs one iteration and increments the count.
  - Multiply: 64-bit shift-add on magnitudes, one multiplier bit per iteration, LSB first.
  - Divide: restoring divide on magnitudes, one quotient bit per iteration, MSB first.
  - After iteration 32, go to FIX.
- FIX → IDLE: on one unhalted edge, do the sign fix-up and load HI/LO.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0. No trap.
  - Divide by zero, any signedness: LO=0xFFFFFFFF, HI=original `data1_i`.
  - Assert `done_o` for this edge.
- `start_i` in CALC or FIX is ignored. No queuing.
- `busy_o` = (state != IDLE), registered.
- `done_o` is registered.
  - It rises on the FIX→IDLE edge and clears on the next unhalted edge.
  - If `halt_i` is high, it holds.
- `hi_o`/`lo_o` hold the last result until the next FIX edge. Intermediate accumulators never drive the outputs.
- `halt_i`=1: state, count, accumulators, `hi_o`, `lo_o`, `busy_o` and `done_o` all hold. `start_i` is ignored.
- `rst_i` overrides `halt_i`.
  - Takes effect on the next edge: state IDLE, count 0.
  - Reset values: `hi_o`=0, `lo_o`=0, `busy_o`=0, `done_o`=0.
  - A reset mid-CALC or mid-FIX abandons the operation. No result is written.

## Timing
- Start accepted at edge E0: `busy_o`=1 from after E0.
- Iterations run on edges E1..E32. FIX completes at E33.
- Result and `done_o`=1 are visible after E33. `busy_o`=0 after E33.
- Latency is 33 unhalted edges; each halted cycle adds one.
- Back-to-back operation:
  - `start_i` sampled at E33 is ignored (state is FIX there).
  - The next start is accepted at E34 at the earliest.
  - At E34, `done_o` drops and `busy_o` rises on the same edge.
- Reset asserted at edge R: all outputs take their reset values after R.

## Test plan
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF, start at E0 → after E33, HI=0xFFFFFFFE, LO=0x00000001, `done_o` high exactly one cycle, `busy_o` high after E0 through E33.
- MULT: −3 × 7 (0xFFFFFFFD, 0x00000007) → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV: −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU: 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064. Also DIVU 100 / 7 → LO=14, HI=2.
- Halt: MULTU 12345 × 678, `halt_i` high for 5 cycles after E10 → `done_o` after E38, LO=8369910, HI=0. `done_o` held for 3 cycles when a 2-cycle halt starts in the done cycle.
- Reset and ignored start:
  - `start_i` pulsed again at E5 → ignored; the original result is unchanged.
  - `rst_i` at E20 of a divide → after E20, `busy_o`=0, `done_o`=0, HI=LO=0, and no `done_o` follows.
  - A fresh start after reset runs a full 33 edges.
